// File: rtl/atm_txn_arbiter_if.sv
// Requester-side bus of the ATM transaction arbiter.
// The terminals use the master modport and the arbiter uses the slave modport.
// Each terminal gets its own slice of every command field. Port k of req_op sits at [3k+2:3k].
interface atm_txn_arbiter_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]    req;
    logic [3*N_REQ-1:0]  req_op;
    logic [4*N_REQ-1:0]  req_acc;
    logic [14*N_REQ-1:0] req_pin;
    logic [14*N_REQ-1:0] req_newpin;
    logic [16*N_REQ-1:0] req_amount;
    logic [N_REQ-1:0]    req_lang;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    rsp_valid;
    logic [31:0]         rsp_balance;
    logic                rsp_success;
    logic                rsp_locked;
    logic                busy;

    modport master (
        output req, req_op, req_acc, req_pin, req_newpin, req_amount, req_lang,
        input  gnt, rsp_valid, rsp_balance, rsp_success, rsp_locked, busy
    );

    modport slave (
        input  req, req_op, req_acc, req_pin, req_newpin, req_amount, req_lang,
        output gnt, rsp_valid, rsp_balance, rsp_success, rsp_locked, busy
    );
endinterface

// File: rtl/atm_txn_arbiter.sv
// atm_txn_arbiter: shares one ATM core among N_REQ terminals.
//
// A round-robin arbiter picks one request and latches its command onto the core inputs.
// The core is then taken out of reset for HOLD_CYCLES cycles. At the end of that window the
// core's balance and success are captured and returned to the granted terminal.
// FSM sequence: IDLE -> SETUP -> RUN -> RESP -> IDLE. All outputs come from registers.
//
// Optional feature, enabled by defining ATM_LOCKOUT_EN:
//   - A failure counter is kept per account (16 entries) and saturates at MAX_FAILS.
//   - A grant whose account counter is already at MAX_FAILS never reaches the core. It goes
//     through REJECT and then RESP, answered with rsp_locked=1.
// Without the macro, REJECT is unreachable and rsp_locked stays 0.
module atm_txn_arbiter #(
    parameter int N_REQ       = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int MAX_FAILS   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    atm_txn_arbiter_if.slave   bus,
    output logic               core_rst,
    output logic [2:0]         core_operation,
    output logic [3:0]         core_acc_num,
    output logic [13:0]        core_pin,
    output logic [13:0]        core_newpin,
    output logic [15:0]        core_amount,
    output logic               core_language,
    input  logic [31:0]        core_balance,
    input  logic               core_success
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        RUN    = 3'd2,
        REJECT = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   rr_ptr_reg;
    logic [IDX_W-1:0]   sel_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               txn_locked_reg;
    logic               busy_reg;
    logic               core_rst_reg;
    logic [2:0]         core_op_reg;
    logic [3:0]         core_acc_reg;
    logic [13:0]        core_pin_reg;
    logic [13:0]        core_newpin_reg;
    logic [15:0]        core_amount_reg;
    logic               core_lang_reg;
    logic [N_REQ-1:0]   gnt_reg;
    logic [N_REQ-1:0]   rsp_valid_reg;
    logic [31:0]        rsp_balance_reg;
    logic               rsp_success_reg;
    logic               rsp_locked_reg;

    // ------------------------------------------------------------------
    // Round-robin search. Candidate gi is the port gi positions after the pointer,
    // wrapping around. The lowest offset with an active request wins.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]   cand_idx [N_REQ];
    logic [N_REQ-1:0]   cand_req;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum = {1'b0, rr_ptr_reg} + (IDX_W+1)'(gi);
            assign cand_idx[gi] = (sum >= (IDX_W+1)'(N_REQ))
                                ? IDX_W'(sum - (IDX_W+1)'(N_REQ))
                                : sum[IDX_W-1:0];
            assign cand_req[gi] = bus.req[cand_idx[gi]];
        end
    endgenerate

    // Priority pick across the rotated candidates: scan downwards so the nearest one wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand_req[i]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx[i];
            end
        end
    end

    // Command fields of the picked port.
    logic [2:0]  pick_op;
    logic [3:0]  pick_acc;
    logic [13:0] pick_pin;
    logic [13:0] pick_newpin;
    logic [15:0] pick_amount;
    logic        pick_lang;

    assign pick_op     = bus.req_op[3*pick_idx +: 3];
    assign pick_acc    = bus.req_acc[4*pick_idx +: 4];
    assign pick_pin    = bus.req_pin[14*pick_idx +: 14];
    assign pick_newpin = bus.req_newpin[14*pick_idx +: 14];
    assign pick_amount = bus.req_amount[16*pick_idx +: 16];
    assign pick_lang   = bus.req_lang[pick_idx];

    // One-hot masks for the picked port and for the port currently being served.
    logic [N_REQ-1:0] pick_onehot;
    logic [N_REQ-1:0] sel_onehot;
    assign pick_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
    assign sel_onehot  = {{(N_REQ-1){1'b0}}, 1'b1} << sel_reg;

    // After a port is served, the pointer moves one past it, so that port gets the lowest priority next time.
    logic [IDX_W-1:0] ptr_after_sel;
    assign ptr_after_sel = (sel_reg == IDX_W'(N_REQ - 1)) ? '0 : sel_reg + 1'b1;

    // ------------------------------------------------------------------
    // Account lockout
    // ------------------------------------------------------------------
    logic pick_locked;

`ifdef ATM_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);

    logic [16*FAIL_W-1:0] fail_cnt_flat;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_fail
            logic [FAIL_W-1:0] fail_cnt_reg;

            // An issued transaction updates the counter of its own account during RESP.
            // Success clears the counter; a failure counts up until it reaches MAX_FAILS.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    fail_cnt_reg <= '0;
                end else if (state_reg == RESP && !txn_locked_reg &&
                             core_acc_reg == 4'(gi)) begin
                    if (rsp_success_reg)
                        fail_cnt_reg <= '0;
                    else if (fail_cnt_reg != FAIL_W'(MAX_FAILS))
                        fail_cnt_reg <= fail_cnt_reg + 1'b1;
                end
            end

            assign fail_cnt_flat[gi*FAIL_W +: FAIL_W] = fail_cnt_reg;
        end
    endgenerate

    assign pick_locked = (fail_cnt_flat[pick_acc*FAIL_W +: FAIL_W] == FAIL_W'(MAX_FAILS));
`else
    assign pick_locked = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Transaction FSM and all registered outputs.
    // A reset in mid-transaction drops core_rst at once and suppresses the response.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            rr_ptr_reg      <= '0;
            sel_reg         <= '0;
            cnt_reg         <= '0;
            txn_locked_reg  <= 1'b0;
            busy_reg        <= 1'b0;
            core_rst_reg    <= 1'b0;
            core_op_reg     <= '0;
            core_acc_reg    <= '0;
            core_pin_reg    <= '0;
            core_newpin_reg <= '0;
            core_amount_reg <= '0;
            core_lang_reg   <= 1'b0;
            gnt_reg         <= '0;
            rsp_valid_reg   <= '0;
            rsp_balance_reg <= '0;
            rsp_success_reg <= 1'b0;
            rsp_locked_reg  <= 1'b0;
        end else begin
            gnt_reg       <= '0;
            rsp_valid_reg <= '0;
            case (state_reg)
                IDLE: begin
                    core_rst_reg <= 1'b0;
                    if (pick_valid) begin
                        sel_reg         <= pick_idx;
                        core_op_reg     <= pick_op;
                        core_acc_reg    <= pick_acc;
                        core_pin_reg    <= pick_pin;
                        core_newpin_reg <= pick_newpin;
                        core_amount_reg <= pick_amount;
                        core_lang_reg   <= pick_lang;
                        gnt_reg         <= pick_onehot;
                        txn_locked_reg  <= pick_locked;
                        busy_reg        <= 1'b1;
                        state_reg       <= pick_locked ? REJECT : SETUP;
                    end
                end
                SETUP: begin
                    cnt_reg      <= CNT_W'(HOLD_CYCLES - 1);
                    core_rst_reg <= 1'b1;
                    state_reg    <= RUN;
                end
                RUN: begin
                    if (cnt_reg == '0) begin
                        rsp_balance_reg <= core_balance;
                        rsp_success_reg <= core_success;
                        rsp_locked_reg  <= 1'b0;
                        rsp_valid_reg   <= sel_onehot;
                        core_rst_reg    <= 1'b0;
                        state_reg       <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                REJECT: begin
                    rsp_balance_reg <= '0;
                    rsp_success_reg <= 1'b0;
                    rsp_locked_reg  <= 1'b1;
                    rsp_valid_reg   <= sel_onehot;
                    state_reg       <= RESP;
                end
                RESP: begin
                    rr_ptr_reg <= ptr_after_sel;
                    busy_reg   <= 1'b0;
                    state_reg  <= IDLE;
                end
                default: begin
                    core_rst_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    // Output wiring.
    assign bus.gnt         = gnt_reg;
    assign bus.rsp_valid   = rsp_valid_reg;
    assign bus.rsp_balance = rsp_balance_reg;
    assign bus.rsp_success = rsp_success_reg;
    assign bus.rsp_locked  = rsp_locked_reg;
    assign bus.busy        = busy_reg;

    assign core_rst       = core_rst_reg;
    assign core_operation = core_op_reg;
    assign core_acc_num   = core_acc_reg;
    assign core_pin       = core_pin_reg;
    assign core_newpin    = core_newpin_reg;
    assign core_amount    = core_amount_reg;
    assign core_language  = core_lang_reg;

endmodule

// File: tb/tb_atm_txn_arbiter.sv
// Testbench for atm_txn_arbiter (2 ports, HOLD_CYCLES=4, MAX_FAILS=3).
// The core model is a per-account table of balance and success values.
// Expected responses are queued when a request is raised. A monitor pops and checks them on every rsp_valid.
`timescale 1ns/1ps
module tb_atm_txn_arbiter;
    localparam int N_REQ = 2;
    localparam int HOLD  = 4;
    localparam int MAXF  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    atm_txn_arbiter_if #(.N_REQ(N_REQ)) bus ();

    logic        core_rst;
    logic [2:0]  core_operation;
    logic [3:0]  core_acc_num;
    logic [13:0] core_pin;
    logic [13:0] core_newpin;
    logic [15:0] core_amount;
    logic        core_language;
    logic [31:0] core_balance;
    logic        core_success;

    logic [31:0] bal_by_acc  [16];
    logic        succ_by_acc [16];
    assign core_balance = bal_by_acc[core_acc_num];
    assign core_success = succ_by_acc[core_acc_num];

    atm_txn_arbiter #(.N_REQ(N_REQ), .HOLD_CYCLES(HOLD), .MAX_FAILS(MAXF)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .core_rst       (core_rst),
        .core_operation (core_operation),
        .core_acc_num   (core_acc_num),
        .core_pin       (core_pin),
        .core_newpin    (core_newpin),
        .core_amount    (core_amount),
        .core_language  (core_language),
        .core_balance   (core_balance),
        .core_success   (core_success)
    );

    typedef struct {
        int          port;
        logic [31:0] bal;
        logic        succ;
        logic        locked;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   cyc       = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [N_REQ-1:0] oh(input int k);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Scoreboard monitor: each response is checked against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.rsp_valid !== '0) begin
            if (sb_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_rsp: rsp_valid=%b with no transaction outstanding", bus.rsp_valid);
            end else begin
                mon_e = sb_q.pop_front();
                total_cnt++;
                if (bus.rsp_valid !== oh(mon_e.port) || bus.rsp_balance !== mon_e.bal ||
                    bus.rsp_success !== mon_e.succ || bus.rsp_locked !== mon_e.locked)
                    $display("FAIL rsp_check: got vld=%b bal=%0d succ=%b lock=%b, expected vld=%b bal=%0d succ=%b lock=%b",
                             bus.rsp_valid, bus.rsp_balance, bus.rsp_success, bus.rsp_locked,
                             oh(mon_e.port), mon_e.bal, mon_e.succ, mon_e.locked);
                else begin
                    pass_cnt++;
                    $display("rsp port=%0d bal=%0d succ=%b locked=%b", mon_e.port,
                             bus.rsp_balance, bus.rsp_success, bus.rsp_locked);
                end
            end
        end
    end

    task automatic set_cmd(input int k, input logic [2:0] op, input logic [3:0] acc,
                           input logic [13:0] pin, input logic [15:0] amt);
        bus.req_op[3*k +: 3]       = op;
        bus.req_acc[4*k +: 4]      = acc;
        bus.req_pin[14*k +: 14]    = pin;
        bus.req_newpin[14*k +: 14] = pin + 14'd1;
        bus.req_amount[16*k +: 16] = amt;
        bus.req_lang[k]            = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.req = '0;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Bounded wait for a grant. Returns at the negedge where gnt is visible.
    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.gnt !== '0) begin
                ok = 1'b1;
                return;
            end
        end
        total_cnt++;
        $display("FAIL gnt_timeout: gnt=%b, expected a grant within 30 cycles", bus.gnt);
    endtask

    // One transaction on port k for account acc. Checks latency and how many cycles core_rst is high.
    task automatic run_txn(input int k, input logic [3:0] acc, input bit locked);
        bit ok;
        int n;
        int hi;
        exp_t e;
        e.port   = k;
        e.bal    = locked ? 32'd0 : bal_by_acc[acc];
        e.succ   = locked ? 1'b0 : succ_by_acc[acc];
        e.locked = locked;
        set_cmd(k, 3'd2, acc, 14'd100 + 14'(acc), 16'd50);
        sb_q.push_back(e);
        bus.req[k] = 1'b1;
        wait_gnt(ok);
        if (!ok) return;
        total_cnt++;
        if (bus.gnt !== oh(k) || core_acc_num !== acc)
            $display("FAIL txn_gnt: gnt=%b acc=%0d, expected gnt=%b acc=%0d", bus.gnt, core_acc_num, oh(k), acc);
        else pass_cnt++;
        bus.req[k] = 1'b0;
        n  = 0;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (core_rst === 1'b1) hi++;
            if (bus.rsp_valid !== '0) break;
        end
        total_cnt++;
        if (n !== (locked ? 1 : HOLD + 1) || hi !== (locked ? 0 : HOLD))
            $display("FAIL txn_timing: latency=%0d core_rst_high=%0d, expected latency=%0d high=%0d",
                     n, hi, locked ? 1 : HOLD + 1, locked ? 0 : HOLD);
        else pass_cnt++;
        $display("txn port=%0d acc=%0d locked=%0b latency=%0d", k, acc, locked, n);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total_cnt++;
            if (bus.gnt !== '0 || bus.rsp_valid !== '0 || core_rst !== 1'b0 || bus.busy !== 1'b0)
                $display("FAIL reset_outputs: gnt=%b vld=%b core_rst=%b busy=%b, expected all 0",
                         bus.gnt, bus.rsp_valid, core_rst, bus.busy);
            else pass_cnt++;
        end
        total_cnt++;
        if (core_acc_num !== 4'd0 || bus.rsp_balance !== 32'd0 || bus.rsp_locked !== 1'b0)
            $display("FAIL reset_regs: acc=%0d bal=%0d lock=%b, expected 0", core_acc_num, bus.rsp_balance, bus.rsp_locked);
        else pass_cnt++;
        bus.req = '0;
        rst_n   = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (bus.busy !== 1'b0 || bus.gnt !== '0)
            $display("FAIL idle_no_req: busy=%b gnt=%b, expected 0", bus.busy, bus.gnt);
        else pass_cnt++;
        $display("reset test done");
    endtask

    task automatic test_single();
        bit ok;
        exp_t e;
        bal_by_acc[1]  = 32'd5000;
        succ_by_acc[1] = 1'b1;
        set_cmd(0, 3'd3, 4'd1, 14'd1234, 16'd0);
        e.port = 0; e.bal = 32'd5000; e.succ = 1'b1; e.locked = 1'b0;
        sb_q.push_back(e);
        bus.req[0] = 1'b1;
        wait_gnt(ok);
        if (!ok) return;
        total_cnt++;
        if (bus.gnt !== 2'b01 || core_operation !== 3'd3 || core_acc_num !== 4'd1 ||
            core_pin !== 14'd1234 || bus.busy !== 1'b1)
            $display("FAIL single_grant: gnt=%b op=%0d acc=%0d pin=%0d busy=%b, expected 01/3/1/1234/1",
                     bus.gnt, core_operation, core_acc_num, core_pin, bus.busy);
        else pass_cnt++;
        bus.req[0] = 1'b0;
        for (int i = 1; i <= HOLD + 1; i++) begin
            @(negedge clk);
            total_cnt++;
            if (core_rst !== (i <= HOLD) || bus.rsp_valid !== ((i == HOLD + 1) ? 2'b01 : 2'b00) ||
                bus.gnt !== 2'b00)
                $display("FAIL single_cycle%0d: core_rst=%b vld=%b gnt=%b, expected core_rst=%b vld=%b gnt=00",
                         i, core_rst, bus.rsp_valid, bus.gnt, (i <= HOLD), (i == HOLD + 1) ? 2'b01 : 2'b00);
            else pass_cnt++;
        end
        bal_by_acc[1]  = 32'd9;
        succ_by_acc[1] = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (bus.rsp_balance !== 32'd5000 || bus.rsp_success !== 1'b1 || core_acc_num !== 4'd1)
            $display("FAIL single_hold: bal=%0d succ=%b acc=%0d, expected 5000/1/1",
                     bus.rsp_balance, bus.rsp_success, core_acc_num);
        else pass_cnt++;
        bal_by_acc[1]  = 32'd1001;
        succ_by_acc[1] = 1'b1;
        $display("single txn test done");
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   g;
        int   last;
        do_reset();
        set_cmd(0, 3'd1, 4'd3, 14'd33, 16'd10);
        set_cmd(1, 3'd1, 4'd4, 14'd44, 16'd20);
        bal_by_acc[3] = 32'd300;
        bal_by_acc[4] = 32'd400;
        for (int i = 0; i < 4; i++) begin
            e.port = i % 2; e.bal = (i % 2) ? 32'd400 : 32'd300; e.succ = 1'b1; e.locked = 1'b0;
            sb_q.push_back(e);
        end
        bus.req = 2'b11;
        g    = 0;
        last = 0;
        for (int i = 0; i < 60 && g < 4; i++) begin
            @(negedge clk);
            if (bus.gnt !== '0) begin
                total_cnt++;
                if (bus.gnt !== oh(g % 2) || core_acc_num !== ((g % 2) ? 4'd4 : 4'd3) ||
                    (g > 0 && (cyc - last) !== HOLD + 3))
                    $display("FAIL rr_grant%0d: gnt=%b acc=%0d spacing=%0d, expected gnt=%b acc=%0d spacing=%0d",
                             g, bus.gnt, core_acc_num, cyc - last, oh(g % 2), (g % 2) ? 4 : 3, HOLD + 3);
                else pass_cnt++;
                $display("rr grant %0d gnt=%b cycle=%0d", g, bus.gnt, cyc);
                last = cyc;
                g++;
                if (g == 4) bus.req = '0;
            end
        end
        total_cnt++;
        if (g !== 4) $display("FAIL rr_count: grants=%0d, expected 4", g);
        else pass_cnt++;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        total_cnt++;
        if (sb_q.size() !== 0) $display("FAIL rr_drain: outstanding=%0d, expected 0", sb_q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_midrun();
        bit ok;
        exp_t e;
        set_cmd(0, 3'd1, 4'd6, 14'd66, 16'd0);
        set_cmd(1, 3'd1, 4'd7, 14'd77, 16'd0);
        bus.req[0] = 1'b1;
        wait_gnt(ok);
        if (!ok) return;
        bus.req[0] = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (core_rst !== 1'b1) $display("FAIL midrun_run2: core_rst=%b, expected 1", core_rst);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (core_rst !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL midrun_async: core_rst=%b busy=%b, expected 0/0", core_rst, bus.busy);
        else pass_cnt++;
        bus.req = 2'b11;
        for (int i = 0; i < HOLD + 3; i++) begin
            @(negedge clk);
            total_cnt++;
            if (bus.rsp_valid !== '0 || core_rst !== 1'b0)
                $display("FAIL midrun_quiet: vld=%b core_rst=%b, expected 0", bus.rsp_valid, core_rst);
            else pass_cnt++;
        end
        e.port = 0; e.bal = bal_by_acc[6]; e.succ = succ_by_acc[6]; e.locked = 1'b0;
        sb_q.push_back(e);
        rst_n = 1'b1;
        wait_gnt(ok);
        if (!ok) return;
        total_cnt++;
        if (bus.gnt !== 2'b01) $display("FAIL midrun_first: gnt=%b, expected 01", bus.gnt);
        else pass_cnt++;
        bus.req = '0;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        total_cnt++;
        if (sb_q.size() !== 0) $display("FAIL midrun_drain: outstanding=%0d, expected 0", sb_q.size());
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_lockout();
        do_reset();
        bal_by_acc[2]  = 32'd321;
        succ_by_acc[2] = 1'b0;
        for (int i = 0; i < 3; i++) run_txn(0, 4'd2, 1'b0);
`ifdef ATM_LOCKOUT_EN
        run_txn(1, 4'd2, 1'b1);
`else
        run_txn(1, 4'd2, 1'b0);
`endif
        succ_by_acc[5] = 1'b1;
        run_txn(0, 4'd5, 1'b0);
    endtask

    task automatic test_lockout_recovery();
        bit pattern [5];
        pattern = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            succ_by_acc[2] = pattern[i];
            run_txn(i % 2, 4'd2, 1'b0);
        end
        succ_by_acc[2] = 1'b0;
        run_txn(0, 4'd2, 1'b0);
`ifdef ATM_LOCKOUT_EN
        run_txn(1, 4'd2, 1'b1);
`else
        run_txn(1, 4'd2, 1'b0);
`endif
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            bal_by_acc[i]  = 32'd1000 + 32'(i);
            succ_by_acc[i] = 1'b1;
        end
        bus.req        = '0;
        bus.req_op     = '0;
        bus.req_acc    = '0;
        bus.req_pin    = '0;
        bus.req_newpin = '0;
        bus.req_amount = '0;
        bus.req_lang   = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_reset_midrun();
        test_lockout();
        test_lockout_recovery();
        repeat (3) @(negedge clk);
        total_cnt++;
        if (sb_q.size() !== 0) $display("FAIL final_drain: outstanding=%0d, expected 0", sb_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
